// File: rtl/fetch_seq.sv
// fetch_seq -- instruction-fetch sequencer for the single-issue core.
//
// Owns the program counter. Issues one instruction-memory request at a time
// (req/ready), hands each fetched word to decode (valid/ready), and applies
// exception vectoring, branch/jump redirects and hazard stalls.
//
// Build option: FETCH_ALIGN_CHECK_EN
//   defined   : a redirect to a non-word-aligned target is refused; the
//               sequencer vectors to EXC_VECTOR and pulses fetch_fault.
//   undefined : fetch_fault is tied low and redir_target[1:0] are ignored.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   pc_next         value pc_cur takes at the next clock edge
//   pc_cur          address of the instruction being fetched or held
//   imem_req/addr   memory request and its word address
//   imem_ready      memory accepts the request and returns imem_rdata
//   imem_rdata      instruction word
//   inst_valid      fetched instruction presented to decode
//   inst_data/pc    instruction word and its PC
//   dec_ready       decode accepts the instruction
//   stall           blocks new requests and leaving DELIVER
//   redir_valid     taken branch/jump pulse, with redir_target
//   exc_valid       exception entry pulse
//   fetch_fault     misaligned-redirect fault pulse
module fetch_seq #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pc_next,
    output logic [ADDR_W-1:0] pc_cur,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    output logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              dec_ready,
    input  logic              stall,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_target,
    input  logic              exc_valid,
    output logic              fetch_fault
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_DELIVER = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [31:0]       inst_data_q, inst_data_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;

    logic              take;         // any redirect this cycle
    logic              bad_align;    // refused misaligned redirect
    logic [ADDR_W-1:0] redir_addr;   // address chosen by priority
    logic [1:0]        refill_state; // where to go when a new fetch is due

    assign take         = exc_valid || redir_valid;
    assign refill_state = stall ? S_IDLE : S_REQ;

`ifdef FETCH_ALIGN_CHECK_EN
    assign bad_align  = redir_valid && !exc_valid && (redir_target[1:0] != 2'b00);
    assign redir_addr = (exc_valid || bad_align) ? EXC_VECTOR : redir_target;
`else
    assign bad_align  = 1'b0;
    assign redir_addr = exc_valid ? EXC_VECTOR
                                  : (redir_target & ~{{(ADDR_W-2){1'b0}}, 2'b11});
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;
        case (state_q)
            S_IDLE: begin
                if (take) begin
                    pc_d = redir_addr;
                end
                state_d = refill_state;
            end
            S_REQ: begin
                if (imem_ready) begin
                    if (take) begin
                        // Redirect coincides with the response: the fresh
                        // redirect supersedes both the data and any pending one.
                        pc_d         = redir_addr;
                        pend_valid_d = 1'b0;
                        state_d      = refill_state;
                    end else if (pend_valid_q) begin
                        // Response belongs to a killed path; drop it.
                        pc_d         = pend_addr_q;
                        pend_valid_d = 1'b0;
                        state_d      = refill_state;
                    end else begin
                        inst_data_d = imem_rdata;
                        inst_pc_d   = pc_q;
                        pc_d        = pc_q + ADDR_W'(4);
                        state_d     = S_DELIVER;
                    end
                end else if (take) begin
                    // The request in flight cannot be aborted; remember
                    // where to go once it completes (latest redirect wins).
                    pend_valid_d = 1'b1;
                    pend_addr_d  = redir_addr;
                end
            end
            S_DELIVER: begin
                if (take) begin
                    pc_d    = redir_addr;
                    state_d = refill_state;
                end else if (dec_ready) begin
                    state_d = refill_state;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= bad_align;
        end
    end
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    // Request and valid come straight from state so an async reset drops
    // them immediately.
    assign pc_next    = pc_d;
    assign pc_cur     = pc_q;
    assign imem_req   = (state_q == S_REQ);
    assign imem_addr  = pc_q;
    assign inst_valid = (state_q == S_DELIVER);
    assign inst_data  = inst_data_q;
    assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed testbench for fetch_seq with a transaction-level reference model.
module tb_fetch_seq;

    localparam logic [31:0] EXC   = 32'h0000_0080;
    localparam logic [31:0] MAGIC = 32'h5A5A_0000;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_next, pc_cur, imem_addr, inst_data, inst_pc, redir_target, imem_rdata;
    logic        imem_req, imem_ready, inst_valid, dec_ready, stall, redir_valid, exc_valid, fetch_fault;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Memory returns a word derived from its address.
    assign imem_rdata = imem_addr ^ MAGIC;

    fetch_seq dut (
        .clk(clk), .rst(rst), .pc_next(pc_next), .pc_cur(pc_cur),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_data(inst_data),
        .inst_pc(inst_pc), .dec_ready(dec_ready), .stall(stall),
        .redir_valid(redir_valid), .redir_target(redir_target),
        .exc_valid(exc_valid), .fetch_fault(fetch_fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // busy: a request is outstanding; hold: an instruction waits for decode;
    // kill: the outstanding response must be dropped, then fetch kaddr.
    typedef struct packed {
        logic        busy;
        logic        hold;
        logic        kill;
        logic [31:0] kaddr;
        logic [31:0] pc;
        logic [31:0] data;
        logic [31:0] ipc;
        logic        fault;
    } mstate_t;

    mstate_t m, m_pred;

    function automatic mstate_t nxt(input mstate_t cur);
        mstate_t     n;
        logic        any_redir;
        logic        misal;
        logic [31:0] tgt;
        n         = cur;
        any_redir = exc_valid || redir_valid;
        misal     = redir_valid && !exc_valid && (redir_target[1:0] != 2'b00);
        if (exc_valid || (ALIGN && misal)) tgt = EXC;
        else                               tgt = {redir_target[31:2], 2'b00};
        n.fault = ALIGN && misal;
        if (cur.busy) begin
            if (imem_ready) begin
                n.busy = 1'b0;
                if (any_redir) begin
                    n.pc = tgt; n.kill = 1'b0; n.busy = !stall;
                end else if (cur.kill) begin
                    n.pc = cur.kaddr; n.kill = 1'b0; n.busy = !stall;
                end else begin
                    n.hold = 1'b1; n.data = cur.pc ^ MAGIC; n.ipc = cur.pc; n.pc = cur.pc + 32'd4;
                end
            end else if (any_redir) begin
                n.kill = 1'b1; n.kaddr = tgt;
            end
        end else if (cur.hold) begin
            if (any_redir) begin
                n.hold = 1'b0; n.pc = tgt; n.busy = !stall;
            end else if (dec_ready) begin
                n.hold = 1'b0; n.busy = !stall;
            end
        end else begin
            if (any_redir) n.pc = tgt;
            n.busy = !stall;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '{busy: 1'b0, hold: 1'b0, kill: 1'b0, kaddr: 32'h0, pc: 32'h0,
                         data: 32'h0, ipc: 32'h0, fault: 1'b0};
        else      m <= nxt(m);
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            m_pred = nxt(m);
            chk("m_imem_req", {31'b0, imem_req}, {31'b0, m.busy});
            chk("m_inst_valid", {31'b0, inst_valid}, {31'b0, m.hold});
            chk("m_pc_cur", pc_cur, m.pc);
            chk("m_pc_next", pc_next, m_pred.pc);
            chk("m_fetch_fault", {31'b0, fetch_fault}, {31'b0, m.fault});
            if (m.busy) chk("m_imem_addr", imem_addr, m.pc);
            if (m.hold) begin
                chk("m_inst_data", inst_data, m.data);
                chk("m_inst_pc", inst_pc, m.ipc);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, release 1 time unit after an edge.
    task automatic do_reset(input logic rdy);
        rst = 1'b0;
        stall = 1'b0; redir_valid = 1'b0; exc_valid = 1'b0; redir_target = 32'h0;
        dec_ready = 1'b1; imem_ready = rdy;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        stall = 1'b0; redir_valid = 1'b0; exc_valid = 1'b0; redir_target = 32'h0;
        dec_ready = 1'b1; imem_ready = 1'b1;
        tick();
        tick();
        // Reset state
        chk("rst_pc_cur", pc_cur, 32'h0);
        chk("rst_pc_next", pc_next, 32'h0);
        chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_fetch_fault", {31'b0, fetch_fault}, 32'h0);

        // 1: sequential fetch, always ready
        do_reset(1'b1);
        tick();
        chk("seq_addr0", imem_addr, 32'h0);
        chk("seq_valid_early", {31'b0, inst_valid}, 32'h0);
        tick();
        chk("seq_valid_lat2", {31'b0, inst_valid}, 32'h1);
        chk("seq_ipc0", inst_pc, 32'h0);
        tick();
        chk("seq_addr4", imem_addr, 32'h4);
        tick();
        chk("seq_ipc4", inst_pc, 32'h4);
        tick();
        chk("seq_addr8", imem_addr, 32'h8);
        tick();
        chk("seq_ipc8", inst_pc, 32'h8);

        // 2: decode back-pressure holds the instruction
        do_reset(1'b1);
        dec_ready = 1'b0;
        tick();
        tick();
        chk("hold_ipc", inst_pc, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_valid", {31'b0, inst_valid}, 32'h1);
            chk("hold_data", inst_data, MAGIC);
            chk("hold_ipc", inst_pc, 32'h0);
            chk("hold_noreq", {31'b0, imem_req}, 32'h0);
        end
        dec_ready = 1'b1;
        tick();
        chk("hold_resume_req", {31'b0, imem_req}, 32'h1);
        chk("hold_resume_addr", imem_addr, 32'h4);

        // 3: redirect while request outstanding, response 2 cycles late
        do_reset(1'b0);
        tick();
        redir_valid = 1'b1; redir_target = 32'h100;
        tick();
        redir_valid = 1'b0;
        chk("pend_addr_held1", imem_addr, 32'h0);
        tick();
        chk("pend_addr_held2", imem_addr, 32'h0);
        imem_ready = 1'b1;
        tick();
        chk("pend_discard", {31'b0, inst_valid}, 32'h0);
        chk("pend_newaddr", imem_addr, 32'h100);
        tick();
        chk("pend_deliver_ipc", inst_pc, 32'h100);

        // 3b: second redirect overwrites the pending one
        do_reset(1'b0);
        tick();
        redir_valid = 1'b1; redir_target = 32'h100;
        tick();
        redir_target = 32'h140;
        tick();
        redir_valid = 1'b0; imem_ready = 1'b1;
        tick();
        chk("pend_latest_wins", imem_addr, 32'h140);

        // 4: exception beats redirect
        do_reset(1'b1);
        tick();
        tick();
        exc_valid = 1'b1; redir_valid = 1'b1; redir_target = 32'h200;
        #1;
        chk("exc_pc_next", pc_next, 32'h80);
        tick();
        exc_valid = 1'b0; redir_valid = 1'b0;
        chk("exc_killed", {31'b0, inst_valid}, 32'h0);
        chk("exc_addr", imem_addr, 32'h80);
        tick();
        chk("exc_ipc", inst_pc, 32'h80);

        // 5: stall during outstanding request, PC wrap
        do_reset(1'b0);
        tick();
        redir_valid = 1'b1; redir_target = 32'hFFFF_FFFC; imem_ready = 1'b1;
        tick();
        redir_valid = 1'b0; imem_ready = 1'b0; stall = 1'b1;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("stall_req_kept", {31'b0, imem_req}, 32'h1);
        imem_ready = 1'b1;
        tick();
        chk("stall_delivered", {31'b0, inst_valid}, 32'h1);
        chk("wrap_ipc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_cur", pc_cur, 32'h0);
        tick();
        chk("stall_noreq1", {31'b0, imem_req}, 32'h0);
        chk("stall_valid_drop", {31'b0, inst_valid}, 32'h0);
        tick();
        chk("stall_noreq2", {31'b0, imem_req}, 32'h0);
        stall = 1'b0;
        tick();
        chk("stall_release_req", {31'b0, imem_req}, 32'h1);
        chk("stall_release_addr", imem_addr, 32'h0);

        // 6: misaligned redirect target
        do_reset(1'b1);
        tick();
        tick();
        redir_valid = 1'b1; redir_target = 32'h102;
        tick();
        redir_valid = 1'b0;
        chk("align_fault", {31'b0, fetch_fault}, ALIGN ? 32'h1 : 32'h0);
        chk("align_addr", imem_addr, ALIGN ? 32'h80 : 32'h100);
        tick();
        chk("align_fault_pulse", {31'b0, fetch_fault}, 32'h0);

        // 7: async reset mid-request
        do_reset(1'b0);
        tick();
        chk("async_pre_req", {31'b0, imem_req}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_req_drop", {31'b0, imem_req}, 32'h0);
        chk("async_pc", pc_cur, 32'h0);
        imem_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk("async_restart_addr", imem_addr, 32'h0);
        tick();
        chk("async_restart_ipc", inst_pc, 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Instruction-fetch sequencer. Owns the program counter and drives the next-address input of the PC register.
- Issues one instruction-memory request at a time over a req/ready handshake and delivers each fetched word to decode over a valid/ready handshake.
- Applies branch/jump redirects, exception vectoring and pipeline stalls.
- Sits between the PC register, instruction memory and the decode stage of the single-issue core.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset
- EXC_VECTOR, 32'h0000_0080, fetch address on exception entry
- ADDR_W, 32, address/PC width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- pc_next  out  ADDR_W  next PC value to the PC register
- pc_cur  out  ADDR_W  address of the instruction currently being fetched or held
- imem_req  out  1  instruction memory request
- imem_addr  out  ADDR_W  request address (word aligned)
- imem_ready  in  1  memory accepted the request and returned data this cycle
- imem_rdata  in  32  instruction word, valid when imem_req && imem_ready
- inst_valid  out  1  fetched instruction available to decode
- inst_data  out  32  instruction word
- inst_pc  out  ADDR_W  PC of inst_data
- dec_ready  in  1  decode accepts the instruction this cycle
- stall  in  1  hazard stall; no new request is issued while high
- redir_valid  in  1  branch/jump taken, single-cycle pulse
- redir_target  in  ADDR_W  redirect address
- exc_valid  in  1  exception entry, single-cycle pulse
- fetch_fault  out  1  misaligned-target fault pulse (see Optional Feature)

Behaviour:
- Reset (rst low, async): state=IDLE, pc_cur=RESET_PC, pc_next=RESET_PC, imem_req=0, inst_valid=0, inst_data=0, inst_pc=0, fetch_fault=0, pend_valid=0.
- States: IDLE, REQ, DELIVER.
- IDLE → REQ on first clk after reset release when stall=0; stays in IDLE while stall=1.
- REQ:
  - imem_req=1, imem_addr=pc_cur; address is held stable until imem_ready.
  - On imem_ready with no pending kill: latch inst_data=imem_rdata and inst_pc=pc_cur; set pc_cur=pc_cur+4; go to DELIVER.
  - Latency: data is presented on inst_valid the cycle after imem_ready.
- DELIVER:
  - inst_valid=1; inst_data and inst_pc are held stable until dec_ready.
  - On dec_ready && !stall: go to REQ at pc_cur (back-to-back fetch, one bubble per instruction).
  - On dec_ready && stall: inst_valid drops, go to IDLE.
- Redirect priority: exc_valid > redir_valid > sequential.
  - Chosen address = EXC_VECTOR on exception, otherwise redir_target.
- Redirect in IDLE or DELIVER: drop inst_valid the next cycle (instruction killed), set pc_cur=chosen address, go to REQ (or IDLE if stall=1).
- Redirect in REQ without imem_ready the same cycle:
  - The outstanding request is never aborted.
  - Latch pend_valid=1 and pend_addr=chosen address.
  - When imem_ready arrives, discard imem_rdata, set pc_cur=pend_addr, clear pend_valid, and re-enter REQ.
- Redirect in REQ with imem_ready the same cycle: discard the data, set pc_cur=chosen address, stay in REQ (next cycle).
- A second redirect while pend_valid=1 overwrites pend_addr; the latest one wins.
- stall never cancels an outstanding request; it only blocks issuing a new one and advancing out of DELIVER.
- pc_next is combinational: the value pc_cur takes at the next edge (equals pc_cur when unchanged).
- PC arithmetic wraps modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 = 0.
- Async reset mid-request: imem_req drops immediately; the in-flight response is ignored.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined: a redirect whose redir_target[1:0]!=0 is not taken. fetch_fault pulses for 1 cycle, and the sequencer vectors to EXC_VECTOR as if exc_valid were asserted.
- Undefined: fetch_fault is tied to 0, and the low 2 bits of redir_target are forced to 0.

Test Plan:
- Reset release, imem_ready=1 always, dec_ready=1 → imem_addr sequence 0x0, 0x4, 0x8; inst_pc matches each; first inst_valid 2 cycles after reset release.
- Hold dec_ready=0 for 3 cycles in DELIVER → inst_data/inst_pc held stable, no imem_req; resume at next address.
- redir_valid with target 0x100 while in REQ, imem_ready delayed 2 cycles → imem_addr unchanged until ready, response discarded (no inst_valid), next request at 0x100.
- exc_valid and redir_valid (0x200) in the same cycle → next fetch at 0x80.
- stall=1 during outstanding request → request completes and is delivered, no new imem_req until stall=0; PC at 0xFFFF_FFFC wraps to 0x0.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x102 → fetch_fault=1 for one cycle, next fetch 0x80; without it, next fetch 0x100.
